piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out stage feeding the bit-serial pattern detectors (e.g. the
//   1010 detector) one bit per clk. Accepts a WIDTH-bit word over a valid/ready
//   handshake and shifts it out on ser_out, marked by ser_valid. Supports
//   back-to-back words with no idle bubble, so a detector sees a continuous stream.
// PARAMETERS
//   WIDTH      8  bits per word; legal range 2..32
//   MSB_FIRST  1  1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
//   IDLE_BIT   0  value driven on ser_out while no word is being shifted
// PORTS
//   clk         in   1      system clock, all state updates on posedge
//   rst_n       in   1      asynchronous, active-low reset
//   data_in     in   WIDTH  parallel word, sampled only when data_valid && data_ready
//   data_valid  in   1      upstream has a word on data_in
//   data_ready  out  1      serializer accepts a word at this edge (combinational)
//   ser_out     out  1      serial bit stream, registered
//   ser_valid   out  1      ser_out carries a real data bit this cycle, registered
//   busy        out  1      a word is in flight (== ser_valid)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, shift reg=0, bit_cnt=0, ser_out=IDLE_BIT,
//     ser_valid=0, busy=0. Release takes effect at the first posedge with rst_n=1.
//   States: IDLE (no word) and SHIFT (bit_cnt = index of bit currently on ser_out).
//   data_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1).
//   Accept = data_valid && data_ready at a posedge. On accept:
//     ser_out <= first bit of data_in; remaining WIDTH-1 bits to shift reg;
//     bit_cnt <= 0; ser_valid <= 1; state <= SHIFT.
//   Latency: first bit visible on ser_out in the cycle after the accepting edge;
//     bit k visible k+1 cycles after it; a word occupies exactly WIDTH cycles.
//   SHIFT, bit_cnt < WIDTH-1: ser_out <= next bit, bit_cnt <= bit_cnt+1;
//     data_valid ignored, data_in not sampled.
//   SHIFT, bit_cnt == WIDTH-1: accept -> load new word as above (no gap);
//     else ser_out <= IDLE_BIT, ser_valid <= 0, state <= IDLE.
//   Bit order per MSB_FIRST; shifting is a logical shift, no sign extension.
//   bit_cnt width = $clog2(WIDTH); never exceeds WIDTH-1, no wrap.
//   data_valid may drop or change without handshake; only accepting edges matter.
//   Reset asserted mid-word: word discarded, outputs to reset values immediately;
//     no partial bits resume after release.
// TESTING
//   1 WIDTH=8,MSB_FIRST=1: accept 8'hA0 -> ser_out 1,0,1,0,0,0,0,0 on the 8 cycles
//     after accept, ser_valid=1 for exactly those 8, then ser_out=0, ser_valid=0.
//   2 Back-to-back: 8'hA5 then 8'h3C with data_valid held -> 16 contiguous bits
//     1010_0101_0011_1100, ser_valid never drops, data_ready high only in the
//     idle cycle and in the cycles carrying bit 7 of each word.
//   3 Valid held while busy, data_in changed mid-word from 8'hFF to 8'h00 -> first
//     word streams as all ones, unaffected; 8'h00 accepted only at bit_cnt==7.
//   4 MSB_FIRST=0, WIDTH=4: accept 4'b0101 -> ser_out 1,0,1,0.
//     Chained into the 1010 detector: detector out pulses once, one cycle after
//     the final 0 is sampled.
//   5 rst_n pulled low at bit 3 of 8'hFF -> ser_out=0, ser_valid=0, data_ready=1
//     immediately (no clock edge); after release no residual bits are emitted.
//   6 data_valid pulse in IDLE lasting one cycle -> exactly one word accepted,
//     busy high for 8 cycles.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and streams
// it one bit per clock on ser_out. Back-to-back words are chained without a gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-2:0] sreg, sreg_nxt, sreg_shifted, rest_bits;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             ser_out_nxt, ser_valid_nxt;
  logic             first_bit, next_bit, accept;

  // Bit order only changes which end of the word leaves first and the shift direction.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit    = data_in[WIDTH-1];
      assign rest_bits    = data_in[WIDTH-2:0];
      assign next_bit     = sreg[WIDTH-2];
      assign sreg_shifted = sreg << 1;
    end else begin : g_lsb
      assign first_bit    = data_in[0];
      assign rest_bits    = data_in[WIDTH-1:1];
      assign next_bit     = sreg[0];
      assign sreg_shifted = sreg >> 1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      bit_cnt   <= cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    cnt_nxt       = bit_cnt;
    ser_out_nxt   = ser_out;
    ser_valid_nxt = ser_valid;
    if (accept) begin
      state_nxt     = SHIFT;
      sreg_nxt      = rest_bits;
      cnt_nxt       = '0;
      ser_out_nxt   = first_bit;
      ser_valid_nxt = 1'b1;
    end else if (state == SHIFT) begin
      if (bit_cnt != LAST) begin
        sreg_nxt    = sreg_shifted;
        cnt_nxt     = bit_cnt + 1'b1;
        ser_out_nxt = next_bit;
      end else begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        ser_out_nxt   = IDLE_BIT;
        ser_valid_nxt = 1'b0;
      end
    end
  end

  // Ready during the last bit lets the next word follow with no bubble.
  always_comb begin
    data_ready = (state == IDLE) || (bit_cnt == LAST);
    accept     = data_valid && data_ready;
    busy       = ser_valid;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based stream model for an 8-bit MSB-first instance,
// plus a 4-bit LSB-first instance feeding a behavioural 1010 detector.
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid, data_ready, ser_out, ser_valid, busy;
  logic [3:0] d4_data;
  logic       d4_valid, d4_ready, d4_ser_out, d4_ser_valid, d4_busy;

  int checks = 0;
  int failures = 0;
  bit q[$];               // bits still to appear on ser_out, front = bit on the wire now
  logic [3:0] hist;
  int det_hits;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4_data), .data_valid(d4_valid),
    .data_ready(d4_ready), .ser_out(d4_ser_out), .ser_valid(d4_ser_valid), .busy(d4_busy));

  // Behavioural 1010 detector on the 4-bit instance's stream.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= 4'b0;
      det_hits <= 0;
    end else if (d4_ser_valid) begin
      hist <= {hist[2:0], d4_ser_out};
      if ({hist[2:0], d4_ser_out} == 4'b1010) det_hits <= det_hits + 1;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the 8-bit instance, checked against the queue model.
  task automatic cyc(input logic v, input logic [7:0] d);
    logic acc;
    data_valid = v;
    data_in    = d;
    #1;
    chk("data_ready", data_ready, q.size() <= 1);
    acc = v && (q.size() <= 1);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
    #1;
    chk("ser_valid", ser_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("ser_out", ser_out, (q.size() != 0) ? q[0] : 1'b0);
  endtask

  initial begin
    logic [3:0] exp4;
    rst_n = 1'b0; data_valid = 1'b0; data_in = '0; d4_valid = 1'b0; d4_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", data_ready, 1'b1);
    rst_n = 1'b1;

    // Single word 0xA0, then idle
    cyc(1'b1, 8'hA0);
    repeat (10) cyc(1'b0, 8'h00);
    // Back-to-back 0xA5, 0x3C with valid held
    repeat (8) cyc(1'b1, 8'hA5);
    repeat (8) cyc(1'b1, 8'h3C);
    repeat (10) cyc(1'b0, 8'h00);
    // Valid held, data changes mid-word
    repeat (4) cyc(1'b1, 8'hFF);
    repeat (5) cyc(1'b1, 8'h00);
    repeat (10) cyc(1'b0, 8'h00);
    // One-cycle valid pulse in idle
    cyc(1'b1, 8'h5A);
    repeat (10) cyc(1'b0, 8'hC3);

    // Reset mid-word at bit 3 of 0xFF
    cyc(1'b1, 8'hFF);
    repeat (3) cyc(1'b0, 8'h00);
    chk("pre_rst_bit3", ser_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ser_out", ser_out, 1'b0);
    chk("async_rst_ser_valid", ser_valid, 1'b0);
    chk("async_rst_ready", data_ready, 1'b1);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) cyc(1'b0, 8'hFF);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom));
    repeat (10) cyc(1'b0, 8'h00);

    // 4-bit LSB-first instance: 0101 -> 1,0,1,0 and one detector hit
    exp4 = 4'b0101;
    d4_valid = 1'b1; d4_data = 4'b0101;
    cyc(1'b0, 8'h00);
    d4_valid = 1'b0; d4_data = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      chk("d4_ser_valid", d4_ser_valid, 1'b1);
      chk("d4_ser_out", d4_ser_out, exp4[k]);
      cyc(1'b0, 8'h00);
    end
    chk("d4_idle_valid", d4_ser_valid, 1'b0);
    chk("d4_idle_out", d4_ser_out, 1'b0);
    repeat (2) cyc(1'b0, 8'h00);
    checks++;
    assert (det_hits === 1) else begin
      failures++;
      $error("FAIL det_hits observed=%0d expected=1", det_hits);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
